// File: rtl/apb_master.sv
// APB requester: accepts single-beat valid/ready requests and runs APB SETUP/ACCESS
// transfers, returning one response pulse with read data and an error flag.
module apb_master #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int ADDR_LIMIT = 64,
   parameter int TIMEOUT    = 16,
   parameter int READ_LAT   = 1
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [63:0]      LIMIT    = 64'(ADDR_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   // Handshake: a request transfers on any rising edge where req_valid and
   // req_ready are both high; rsp_valid is a single-cycle pulse with no back-pressure.

   state_t            state, state_d;
   logic              psel_d, penable_d, pwrite_d;
   logic [ADDR_W-1:0] paddr_d;
   logic [DATA_W-1:0] pwdata_d;
   logic              rsp_valid_d, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_d;
   logic [CNT_W-1:0]  wdog, wdog_d;
   logic [63:0]       addr_ext;
   logic              in_range;

   assign req_ready = (state == IDLE);
   assign addr_ext  = 64'(req_addr);
   assign in_range  = (addr_ext < LIMIT);

   always_comb begin
      state_d     = state;
      psel_d      = psel;
      penable_d   = penable;
      pwrite_d    = pwrite;
      paddr_d     = paddr;
      pwdata_d    = pwdata;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err;
      rsp_rdata_d = rsp_rdata;
      wdog_d      = wdog;

      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!in_range) begin
                  // Rejected without touching the bus; FSM stays ready for the next one.
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  pwrite_d  = req_write;
                  paddr_d   = req_addr;
                  pwdata_d  = req_write ? req_wdata : '0;
                  state_d   = SETUP;
               end
            end
         end

         SETUP: begin
            penable_d = 1'b1;
            wdog_d    = '0;
            state_d   = ACCESS;
         end

         ACCESS: begin
            if (pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (pwrite) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = '0;
                  state_d     = IDLE;
               end else if (READ_LAT == 0) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = prdata;
                  state_d     = IDLE;
               end else begin
                  state_d = CAPTURE;
               end
            end else if (wdog == CNT_LAST) begin
               // Watchdog expiry: abandon the transfer and report an error.
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = IDLE;
            end else begin
               wdog_d = wdog + 1'b1;
            end
         end

         CAPTURE: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = prdata;
            state_d     = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         wdog      <= '0;
      end else begin
         state     <= state_d;
         psel      <= psel_d;
         penable   <= penable_d;
         pwrite    <= pwrite_d;
         paddr     <= paddr_d;
         pwdata    <= pwdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rsp_rdata <= rsp_rdata_d;
         wdog      <= wdog_d;
      end
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Upstream APB requester. Accepts single-beat read/write requests from a local valid/ready interface and runs full APB SETUP/ACCESS transfers toward the 64-entry APB slave memory.
- Returns one response pulse per accepted request, carrying read data and an error flag.
- Adds an address-range check, a PREADY watchdog timeout, and a configurable read-data capture delay. The delay lets it match a slave that registers PRDATA on the ACCESS-completing edge.

Parameters:
- ADDR_W, 8, width of req_addr and paddr
- DATA_W, 8, width of write/read data
- ADDR_LIMIT, 64, a request is rejected as out of range when req_addr >= ADDR_LIMIT
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort (>=1)
- READ_LAT, 1, 0 = prdata sampled on the completing ACCESS edge; 1 = sampled one cycle later

Ports:
- pclk, input, 1: clock; all logic on rising edge
- preset, input, 1: synchronous, active-high reset
- req_valid, input, 1: request present
- req_ready, output, 1: request accepted when req_valid & req_ready at the edge
- req_write, input, 1: 1 = write, 0 = read
- req_addr, input, ADDR_W: target address
- req_wdata, input, DATA_W: write data
- rsp_valid, output, 1: one-cycle response pulse
- rsp_rdata, output, DATA_W: read data; 0 for writes and errors
- rsp_err, output, 1: out-of-range or timeout; qualified by rsp_valid
- psel, output, 1: APB select
- penable, output, 1: APB enable
- pwrite, output, 1: APB direction
- paddr, output, ADDR_W: APB address
- pwdata, output, DATA_W: APB write data
- pready, input, 1: slave ready
- prdata, input, DATA_W: slave read data

Behaviour:
- Reset (preset=1 at an edge):
  - State becomes IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all clear to 0.
  - Watchdog counter clears to 0.
  - Reset mid-transfer aborts immediately. No response is produced for the aborted request.
- All APB and rsp outputs are registered. req_ready = (state == IDLE), combinational.
- State machine:
  - States: IDLE, SETUP, ACCESS, CAPTURE.
  - rsp_valid defaults to 0 every cycle unless set below.
- IDLE, on accept with req_addr >= ADDR_LIMIT:
  - No bus cycle.
  - At the accepting edge: rsp_valid <= 1, rsp_err <= 1, rsp_rdata <= 0.
  - Stay in IDLE, so back-to-back rejects are possible every cycle.
- IDLE, on accept of an in-range request:
  - psel <= 1, penable <= 0.
  - pwrite, paddr, pwdata loaded from the request. pwdata <= 0 for reads.
  - Go to SETUP.
- SETUP: penable <= 1, watchdog counter <= 0, go to ACCESS.
- ACCESS with pready = 1 at the edge:
  - psel <= 0, penable <= 0.
  - Write: rsp_valid <= 1, rsp_err <= 0, go to IDLE.
  - Read, READ_LAT = 0: rsp_rdata <= prdata, rsp_valid <= 1, go to IDLE.
  - Read, READ_LAT = 1: go to CAPTURE.
- ACCESS with pready = 0:
  - Counter increments.
  - When the counter reaches TIMEOUT-1 with pready still 0: drop psel/penable, rsp_valid <= 1, rsp_err <= 1, rsp_rdata <= 0, go to IDLE.
  - pready arriving on that same edge wins, and the transfer completes normally.
- CAPTURE: rsp_rdata <= prdata, rsp_valid <= 1, rsp_err <= 0, go to IDLE.
- Latency, counted from the accept edge E0 with zero-wait slave:
  - psel high E0..E2; penable high E1..E2.
  - Write: rsp_valid high for the cycle after E2.
  - Read, READ_LAT = 1: rsp_valid high for the cycle after E3.
  - Next accept is possible at E3 (write) or E4 (read).
- APB rules:
  - paddr, pwrite, pwdata are held stable from SETUP through the end of ACCESS.
  - psel and penable never both rise on the same edge.
  - penable is never high without psel.
- Request inputs are ignored while req_ready = 0. The requester must hold them stable only until the accept edge.
- Address boundary:
  - ADDR_LIMIT-1 (63) is issued on the bus.
  - ADDR_LIMIT (64) and 255 are rejected.
- rsp_rdata holds its last value between responses. rsp_err is meaningful only when rsp_valid = 1.

Test Plan:
- Reset while in ACCESS with pready = 0 -> next cycle psel = penable = 0, req_ready = 1, and no rsp_valid pulse occurs.
- Write addr 0x05 data 0xA5 to the slave model, then read 0x05 with READ_LAT = 1 -> write rsp_valid 2 cycles after accept with rsp_err = 0; read rsp_valid 3 cycles after accept with rsp_rdata = 0xA5.
- Write 0x3F data 0x5A, then read 0x3F -> rsp_rdata = 0x5A, rsp_err = 0. Request at 0x40 -> rsp_valid on the accept edge, rsp_err = 1, rsp_rdata = 0, psel never asserted.
- Slave holds pready = 0 with TIMEOUT = 16 -> penable high for exactly 16 cycles, then rsp_err = 1 and req_ready = 1 the following cycle. Repeat with pready rising on the 16th ACCESS cycle -> normal completion, rsp_err = 0.
- Continuous req_valid with 4 alternating writes and reads (0x10: 0x11, 0x20: 0x22, then reads of 0x10 and 0x20) -> exactly 4 rsp pulses in order, reads return 0x11 then 0x22, no overlapping transfers, and APB rules hold on every cycle.
